// File: rtl/serial_load_ctrl_if.sv
// Load-request handshake plus the control lines driven into the shift register.
// The master side issues requests; the slave side is the controller.
interface serial_load_ctrl_if #(
  parameter int unsigned N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sext;
  logic         abort;
  logic         shift_en;
  logic         shift_in;
  logic         extend;
  logic         busy;
  logic         done;

  modport master (
    output in_valid, in_data, in_sext, abort,
    input  in_ready, shift_en, shift_in, extend, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_sext, abort,
    output in_ready, shift_en, shift_in, extend, busy, done
  );
endinterface

// File: rtl/serial_load_ctrl.sv
// Sequencing controller for a shift-register datapath: accepts an N-bit word,
// presents it LSB-first on shift_en/shift_in, optionally holds extend for the
// remaining X-N cycles, then pulses done for one cycle.
module serial_load_ctrl #(
  parameter int unsigned X = 8,
  parameter int unsigned N = 8
) (
  input logic               clk,
  input logic               rst,
  serial_load_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(X + 1);
  localparam bit          ExtAllowed = (X > N);
  localparam logic [CntW-1:0] ShiftLast = CntW'(N - 1);
  // Unused when X == N; the guard keeps the subtraction from wrapping.
  localparam logic [CntW-1:0] ExtLast = ExtAllowed ? CntW'(X - N - 1) : '0;

  typedef enum logic [1:0] {StIdle, StShift, StExtend, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    copy_q;
  logic            sext_q;
  logic            shift_en_q;
  logic            shift_in_q;
  logic            extend_q;
  logic            busy_q;
  logic            done_q;

  logic [N-1:0]    copy_shr;

  // Copy as it will look after this edge's shift; bit 0 is the next bit out.
  assign copy_shr = copy_q >> 1;

  // Only in_ready sees inputs combinationally; rst forces it low immediately.
  assign bus.in_ready = (state_q == StIdle) && !bus.abort && !rst;
  assign bus.shift_en = shift_en_q;
  assign bus.shift_in = shift_in_q;
  assign bus.extend   = extend_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // FSM with outputs registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      copy_q     <= '0;
      sext_q     <= 1'b0;
      shift_en_q <= 1'b0;
      shift_in_q <= 1'b0;
      extend_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && !bus.abort) begin
            copy_q     <= bus.in_data;
            sext_q     <= bus.in_sext && ExtAllowed;
            cnt_q      <= '0;
            state_q    <= StShift;
            shift_en_q <= 1'b1;
            shift_in_q <= bus.in_data[0];
            busy_q     <= 1'b1;
          end
        end

        StShift: begin
          copy_q <= copy_shr;
          if (bus.abort) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sext_q     <= 1'b0;
            shift_en_q <= 1'b0;
            shift_in_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (cnt_q == ShiftLast) begin
            cnt_q      <= '0;
            shift_en_q <= 1'b0;
            shift_in_q <= 1'b0;
            if (sext_q) begin
              state_q  <= StExtend;
              extend_q <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            shift_in_q <= copy_shr[0];
          end
        end

        StExtend: begin
          if (bus.abort) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sext_q   <= 1'b0;
            extend_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (cnt_q == ExtLast) begin
            state_q  <= StDone;
            cnt_q    <= '0;
            extend_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          // Abort here lands in the same place; done was already visible.
          state_q <= StIdle;
          cnt_q   <= '0;
          sext_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          sext_q     <= 1'b0;
          shift_en_q <= 1'b0;
          shift_in_q <= 1'b0;
          extend_q   <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: two instances (X=8/N=8 and X=8/N=4) share one
// stimulus stream; a cycle-timeline model predicts every output each cycle.
module tb_serial_load_ctrl;

  localparam int unsigned X = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v_r = 1'b0;
  logic       s_r = 1'b0;
  logic       a_r = 1'b0;
  logic [7:0] d_r = 8'h00;

  always #5 clk = ~clk;

  serial_load_ctrl_if #(.N(8)) if8 ();
  serial_load_ctrl_if #(.N(4)) if4 ();

  assign if8.in_valid = v_r;
  assign if8.in_data  = d_r;
  assign if8.in_sext  = s_r;
  assign if8.abort    = a_r;
  assign if4.in_valid = v_r;
  assign if4.in_data  = d_r[3:0];
  assign if4.in_sext  = s_r;
  assign if4.abort    = a_r;

  serial_load_ctrl #(.X(X), .N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_load_ctrl #(.X(X), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  // {shift_en, shift_in, extend, busy, done}
  logic [4:0] o_out [2];
  logic [1:0] o_rdy;
  assign o_out[0] = {if8.shift_en, if8.shift_in, if8.extend, if8.busy, if8.done};
  assign o_out[1] = {if4.shift_en, if4.shift_in, if4.extend, if4.busy, if4.done};
  assign o_rdy    = {if4.in_ready, if8.in_ready};

  int errors = 0;
  int checks = 0;

  // Model: t = cycles since the accepting edge; bits occupy t=1..n,
  // extension t=n+1..n+ext, done at t=n+ext+1.
  bit         m_act  [2];
  int         m_t    [2];
  logic [7:0] m_data [2];
  int         m_ext  [2];
  int         nn     [2];

  typedef struct {
    int         d;
    logic [7:0] data;
    bit         sext;
    logic [7:0] bits;
    int         nsh;
    int         next;
    int         nbusy;
    int         done_at;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, d, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_out(input int d);
    logic [4:0] r;
    int         n;
    r = '0;
    n = nn[d];
    if (m_act[d]) begin
      if (m_t[d] <= n) r = {1'b1, m_data[d][m_t[d]-1], 3'b010};
      else if (m_t[d] <= n + m_ext[d]) r = 5'b00110;
      else r = 5'b00011;
    end
    return r;
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check outputs.
  task automatic step(input bit v, input logic [7:0] data, input bit s, input bit a);
    v_r = v; d_r = data; s_r = s; a_r = a;
    #1;
    for (int d = 0; d < 2; d++) check("in_ready", d, 32'(o_rdy[d]), 32'(!m_act[d] && !a));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_act[d]) begin
        if (a || m_t[d] == nn[d] + m_ext[d] + 1) m_act[d] = 1'b0;
        else m_t[d]++;
      end else if (v && !a) begin
        m_act[d]  = 1'b1;
        m_t[d]    = 1;
        m_data[d] = (nn[d] == 8) ? data : {4'h0, data[3:0]};
        m_ext[d]  = (s && X > nn[d]) ? int'(X) - nn[d] : 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) check("outputs", d, 32'(o_out[d]), 32'(model_out(d)));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (!m_act[0] && !m_act[1]) break;
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic run_load(input int d, input logic [7:0] data, input bit sext,
                          output logic [7:0] bits, output int nsh, output int next,
                          output int nbusy, output int done_at);
    bits = '0; nsh = 0; next = 0; nbusy = 0; done_at = 0;
    wait_idle();
    step(1'b1, data, sext, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      if (o_out[d][4]) begin
        if (nsh < 8) bits[nsh] = o_out[d][3];
        nsh++;
      end
      if (o_out[d][2]) next++;
      if (o_out[d][1]) nbusy++;
      if (o_out[d][0]) begin
        done_at = c;
        break;
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  bits;
    logic [15:0] seq;
    int          nsh, next, nbusy, done_at, nbits, first_done;

    nn[0] = 8; nn[1] = 4;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_t[d] = 0; m_data[d] = '0; m_ext[d] = 0;
    end

    tbl[0] = '{d: 0, data: 8'hCA, sext: 1'b0, bits: 8'hCA, nsh: 8, next: 0, nbusy: 9, done_at: 9};
    tbl[1] = '{d: 0, data: 8'hCA, sext: 1'b1, bits: 8'hCA, nsh: 8, next: 0, nbusy: 9, done_at: 9};
    tbl[2] = '{d: 1, data: 8'h0A, sext: 1'b1, bits: 8'h0A, nsh: 4, next: 4, nbusy: 9, done_at: 9};
    tbl[3] = '{d: 1, data: 8'h0A, sext: 1'b0, bits: 8'h0A, nsh: 4, next: 0, nbusy: 5, done_at: 5};
    tbl[4] = '{d: 1, data: 8'h35, sext: 1'b0, bits: 8'h05, nsh: 4, next: 0, nbusy: 5, done_at: 5};
    tbl[5] = '{d: 0, data: 8'h0F, sext: 1'b1, bits: 8'h0F, nsh: 8, next: 0, nbusy: 9, done_at: 9};

    // Reset state while rst is held
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_outputs", d, 32'(o_out[d]), 32'h0);
      check("rst_ready", d, 32'(o_rdy[d]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed loads from the table
    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].d, tbl[i].data, tbl[i].sext, bits, nsh, next, nbusy, done_at);
      check($sformatf("vec%0d_bits", i), tbl[i].d, 32'(bits), 32'(tbl[i].bits));
      check($sformatf("vec%0d_nshift", i), tbl[i].d, nsh, tbl[i].nsh);
      check($sformatf("vec%0d_nextend", i), tbl[i].d, next, tbl[i].next);
      check($sformatf("vec%0d_nbusy", i), tbl[i].d, nbusy, tbl[i].nbusy);
      check($sformatf("vec%0d_done_at", i), tbl[i].d, done_at, tbl[i].done_at);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Abort after three bits, then a clean fresh load of 4'h5
    wait_idle();
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("abort_busy", 1, 32'(o_out[1][1]), 32'h0);
    check("abort_shift_en", 1, 32'(o_out[1][4]), 32'h0);
    check("abort_done", 1, 32'(o_out[1][0]), 32'h0);
    run_load(1, 8'h05, 1'b0, bits, nsh, next, nbusy, done_at);
    check("post_abort_bits", 1, 32'(bits), 32'h05);
    check("post_abort_done_at", 1, done_at, 5);

    // Asynchronous reset in the middle of EXTEND
    wait_idle();
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_extend", 1, 32'(o_out[1][2]), 32'h1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async_rst_outputs", d, 32'(o_out[d]), 32'h0);
      check("async_rst_ready", d, 32'(o_rdy[d]), 32'h0);
    end
    @(posedge clk);
    #1;
    check("rst_hold_outputs", 1, 32'(o_out[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // in_valid held high; data changes mid-operation
    wait_idle();
    seq = '0; nbits = 0; first_done = 0;
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (o_out[0][4] && nbits < 16) begin
        seq[nbits] = o_out[0][3];
        nbits++;
      end
      if (o_out[0][0] && first_done == 0) first_done = c;
      step(1'b1, 8'hF0, 1'b0, 1'b0);
    end
    check("held_valid_seq", 0, 32'(seq), 32'hF00F);
    check("held_valid_first_done", 0, first_done, 9);
    wait_idle();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 11) == 0));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_load_ctrl.md
# serial_load_ctrl

Sequencing controller for the `shift_register` datapath. It accepts a parallel word over a valid/ready handshake and serializes it LSB-first onto `shift_en`/`shift_in` over N cycles. When the request asks for sign extension, it then asserts `extend` for the remaining X−N cycles and pulses `done`. It sits between the operand-issue logic and the shift register, which is the only consumer of its datapath outputs.

## Interface
- `X`, default 8: width of the driven shift register; ≥2.
- `N`, default 8: bits per load; 1 ≤ N ≤ X.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: load request valid.
- `in_ready`  out  1: controller can accept a request.
- `in_data`  in  N: word to serialize; bit 0 is shifted first.
- `in_sext`  in  1: request sign-extension phase after the data bits; sampled with `in_data`.
- `abort`  in  1: synchronous cancel of the current operation.
- `shift_en`  out  1: to shift register; high only in SHIFT.
- `shift_in`  out  1: to shift register; current data bit; 0 outside SHIFT.
- `extend`  out  1: to shift register; high only in EXTEND.
- `busy`  out  1: high in SHIFT, EXTEND and DONE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- State machine with four states: IDLE, SHIFT, EXTEND, DONE. Outputs are decoded from registered state, data and counter only (Moore); there is no input-to-output combinational path except `in_ready`.
- IDLE:
  - `in_ready = !abort`.
  - A handshake occurs when `in_valid && in_ready`. On that edge:
    - `in_data` is latched into an N-bit shift copy.
    - `sext_q` is set to `in_sext && (X > N)`.
    - The bit counter is cleared.
    - The state moves to SHIFT.
- SHIFT:
  - Outputs: `shift_en = 1`, `shift_in = copy[0]`.
  - Each edge shifts the copy right by 1 and increments the counter.
  - When the counter reaches N−1 and the edge occurs, the state goes to EXTEND if `sext_q`, else to DONE. The counter clears.
- EXTEND:
  - Outputs: `extend = 1`, `shift_en = 0`.
  - Lasts exactly X−N cycles, counted by the same counter.
  - On the last cycle's edge, the state goes to DONE.
- DONE:
  - Outputs: `done = 1` for exactly one cycle; `in_ready = 0`.
  - Next edge returns to IDLE.
- `abort = 1` in SHIFT, EXTEND or DONE: the next edge forces IDLE and clears the counter and `sext_q`.
  - No `done` pulse is issued for an aborted operation.
  - In DONE, `done` is still high in that same cycle, because outputs are Moore.
  - `abort` in IDLE blocks acceptance for that cycle only.
- `in_valid`, `in_data` and `in_sext` are ignored outside IDLE. The latched copy is never modified by inputs during an operation.
- Counter width is `$clog2(X+1)`. The counter is never compared against values above X.

## Timing
- Reset (asynchronous, immediate on `rst` rising):
  - State is IDLE; counter, copy and `sext_q` are 0.
  - `shift_en`, `shift_in`, `extend`, `busy` and `done` are all 0.
  - `in_ready = 0` while `rst` is high; it becomes 1 in the first cycle after deassertion.
- Let handshake edge = E0.
  - Bit i (0…N−1) is presented on `shift_in` with `shift_en = 1` in the cycle after edge Ei, so the register samples it on edge E(i+1).
  - With extension: `extend` is high in the cycles following E(N)…E(X−1).
  - `done` is high in the cycle after E(N+ext), where ext = X−N if `sext_q`, else 0.
  - `in_ready` returns in the following cycle.
  - Total occupancy is N + ext + 1 cycles. Maximum throughput is one load per N + ext + 2 cycles.
- `shift_en` and `extend` are never high in the same cycle.
- `rst` asserted mid-operation: outputs drop to 0 within the same cycle, and no `done` is issued.
- N = X: `in_sext` has no effect; the EXTEND state is never entered.

## Test plan
- X=8, N=8, `in_data = 8'hCA`, `in_sext = 0` → `shift_in` sequence 0,1,0,1,0,0,1,1 over 8 cycles with `shift_en = 1`; `extend` never high; `done` in cycle 9 after E0; `in_ready = 1` in cycle 10; a downstream register reads 8'b11001010.
- X=8, N=4, `in_data = 4'hA`, `in_sext = 1` → `shift_in` 0,1,0,1 over 4 cycles, then `extend = 1` for exactly 4 cycles, then a 1-cycle `done`; `busy` is high for 9 cycles.
- Same configuration with `in_sext = 0` → 4 shift cycles, no `extend`, `done` in cycle 5.
- `abort` pulsed after 3 bits have shifted → next cycle `shift_en = 0`, `busy = 0`, `in_ready = 1`; `done` never asserted; a fresh load of 4'h5 then runs cleanly with sequence 1,0,1,0.
- `rst` asserted asynchronously during EXTEND → `extend`, `busy` and `in_ready` go 0 before the next edge; after release, state is IDLE and `in_ready = 1`.
- `in_valid` held high with data 8'h0F, then changed to 8'hF0 mid-operation → the first load shifts 1,1,1,1,0,0,0,0 unaffected; the second load is accepted in the cycle after `done`; a new `in_valid` is never accepted while `busy` is high.
